// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory responder with programmable wait states
// Optional MISALIGN_ERR_EN: flag and suppress accesses whose req_addr[1:0] is nonzero.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH must be a power of 2 and at least 2");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic            cap_we;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
  logic            cap_err;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];
  logic            unused_addr;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req_valid) state_nx = (WAIT_CYCLES == 0) ? S_EXEC : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_nx = S_EXEC;
      S_EXEC: state_nx = S_RESP;
      S_RESP: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cap_we    <= req_we;
          cap_idx   <= req_addr[AW+1:2];
          cap_wdata <= req_wdata;
          cnt       <= CNT_INIT;
        end
        S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        S_EXEC: rdata_q <= (cap_we || cap_err) ? 32'd0 : mem[cap_idx];
        default: ;
      endcase
    end
  end

  // Gated by reset so an aborted transaction never commits.
  always_ff @(posedge clk) begin
    if (reset && state == S_EXEC && cap_we && !cap_err) mem[cap_idx] <= cap_wdata;
  end

`ifdef MISALIGN_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_err <= 1'b0;
      err_q   <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      cap_err <= |req_addr[1:0];
    end else if (state == S_EXEC) begin
      err_q <= cap_err;
    end
  end

  assign rsp_err     = err_q;
  assign unused_addr = ^req_addr[31:AW+2];
`else
  assign cap_err     = 1'b0;
  assign rsp_err     = 1'b0;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for rsp_valid, then take the response.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] held;

  initial begin
    // Reset held for two edges
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

    // Basic write then read with latency
    xact(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("wr10_rdata", rd, 32'd0);
    chk("wr10_err", {31'd0, er}, 32'd0);
    chk("wr10_lat", lat, 3);
    chk("idle_after_wr", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 32'h10, 32'd0, rd, er, lat);
    chk("rd10_rdata", rd, 32'hDEADBEEF);
    chk("rd10_lat", lat, 3);

    // Aliasing modulo DEPTH*4 and the last word
    xact(1'b1, 32'h0, 32'h12345678, rd, er, lat);
    xact(1'b0, 32'h100, 32'd0, rd, er, lat);
    chk("alias_100", rd, 32'h12345678);
    xact(1'b1, 32'h1FC, 32'h0BADCAFE, rd, er, lat);
    xact(1'b0, 32'hFC, 32'd0, rd, er, lat);
    chk("last_word_fc", rd, 32'h0BADCAFE);
    xact(1'b0, 32'h10, 32'd0, rd, er, lat);
    chk("no_clobber_10", rd, 32'hDEADBEEF);

    // Back-pressure: response held while a competing write is presented
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0;
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk("bp_lat", lat, 3);
    held = rsp_rdata;
    chk("bp_first_rdata", held, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata_held", rsp_rdata, 32'h12345678);
      chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    chk("bp_released_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_released_ready", {31'd0, req_ready}, 32'd1);
    xact(1'b0, 32'h10, 32'd0, rd, er, lat);
    chk("bp_write_ignored", rd, 32'hDEADBEEF);

    // Reset during WAIT aborts the write
    xact(1'b1, 32'h20, 32'h11112222, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
    tick();
    req_valid = 1'b0;
    chk("abort_in_wait", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    chk("abort_stays_idle", {31'd0, rsp_valid}, 32'd0);
    xact(1'b0, 32'h20, 32'd0, rd, er, lat);
    chk("abort_old_value", rd, 32'h11112222);

    // Misaligned write
    xact(1'b1, 32'h22, 32'h5A5A5A5A, rd, er, lat);
    chk("mis_wr_rdata", rd, 32'd0);
    chk("mis_wr_lat", lat, 3);
`ifdef MISALIGN_ERR_EN
    chk("mis_wr_err", {31'd0, er}, 32'd1);
`else
    chk("mis_wr_err", {31'd0, er}, 32'd0);
`endif
    xact(1'b0, 32'h20, 32'd0, rd, er, lat);
`ifdef MISALIGN_ERR_EN
    chk("mis_rd_data", rd, 32'h11112222);
`else
    chk("mis_rd_data", rd, 32'h5A5A5A5A);
`endif
    chk("mis_rd_err", {31'd0, er}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Word-addressed data-memory responder that sits on the far side of the processor datapath's load/store interface.
- Accepts one read or write request through a valid/ready handshake.
- Inserts a programmable number of wait states.
- Returns read data or a write acknowledgement through a second valid/ready handshake.
- Used to exercise the core against a non-ideal memory, and as the basis for the later multicycle memory system.

Parameters:
- DEPTH, 64: number of 32-bit words; must be a power of 2, at least 2.
- WAIT_CYCLES, 2: wait states between request accept and response; range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  input  1  requester has a valid request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write (store), 0 = read (load).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for write responses.
- rsp_err  output  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Reset (reset==0 at a rising edge):
  - FSM goes to IDLE; wait counter = 0; capture registers cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory array contents are not reset.
- Word index = req_addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH*4. addr[1:0] are ignored unless MISALIGN_ERR_EN is defined.
- Only one request is outstanding at a time. req_ready=1 only in IDLE.
- Handshake rules:
  - Request accept = req_valid & req_ready at a rising edge.
  - Response transfer = rsp_valid & rsp_ready at a rising edge.
  - Requester may hold req_valid while req_ready=0; responder ignores it.
- FSM states:
  - IDLE:
    - On accept, capture we/index/wdata.
    - If WAIT_CYCLES==0, go to EXEC.
    - Otherwise load counter = WAIT_CYCLES-1 and go to WAIT.
  - WAIT:
    - Counter decrements each cycle.
    - When counter==0, go to EXEC.
  - EXEC (exactly one cycle):
    - Write: mem[index] <= wdata; rsp_rdata <= 0.
    - Read: rsp_rdata <= mem[index].
    - Go to RESP.
  - RESP:
    - rsp_valid=1; rsp_rdata and rsp_err held stable.
    - On rsp_ready, go to IDLE with rsp_valid deasserted the next cycle.
    - The next request cannot be accepted in the same cycle as the response transfer.
- Latency: if the accept happens at edge T, rsp_valid rises after edge T+WAIT_CYCLES+1. Example: WAIT_CYCLES=2 gives rsp_valid visible in cycle T+3.
- Read-after-write to the same index returns the new data, because the write commits in EXEC before the next accept.
- Back-pressure: rsp_ready low holds RESP indefinitely; nothing is lost.
- Reset mid-operation (WAIT/EXEC/RESP):
  - Transaction is aborted; a write not yet in EXEC is not committed.
  - Outputs return to reset values after the edge.
- Counter width is 4 bits; WAIT_CYCLES > 15 is illegal (elaboration check).

Optional Feature:
MISALIGN_ERR_EN
- Defined:
  - Accept with req_addr[1:0]!=0 sets captured err=1.
  - EXEC performs no memory write and forces rsp_rdata=0.
  - RESP presents rsp_err=1. Latency is unchanged.
- Undefined:
  - rsp_err is tied to 0.
  - addr[1:0] are ignored and access proceeds to the word index.

Test Plan:
- Reset: hold reset=0 two cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- WAIT_CYCLES=2: write 0xDEADBEEF @0x10, then read @0x10 -> write rsp_rdata=0; read rsp_rdata=0xDEADBEEF; each rsp_valid exactly 3 cycles after its accept.
- Alias/wrap with DEPTH=64: write 0x12345678 @0x00, read @0x100 -> 0x12345678. Read @0xFC returns the last word.
- Back-pressure: read with rsp_ready=0 for 5 cycles, then 1 -> rsp_valid and rsp_rdata held stable; req_ready=0 throughout; new req_valid ignored until IDLE.
- Reset during WAIT of a write of 0xAAAA5555 @0x20, then read @0x20 -> old value returned (write not committed).
- MISALIGN_ERR_EN defined: write @0x22 then read @0x20 -> write rsp_err=1; memory unchanged; read rsp_err=0. With the macro undefined, the write lands at word 8 and rsp_err stays 0.
